// File: rtl/up_axi_master.sv
// Register-interface to AXI4-Lite master bridge: one outstanding write or read at a time,
// with an optional read queued behind a simultaneous write and a per-state timeout abort.
module up_axi_master #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        up_clk,
    input  logic        up_rst,
    input  logic        up_wreq,
    input  logic [13:0] up_waddr,
    input  logic [31:0] up_wdata,
    output logic        up_wack,
    output logic        up_werr,
    input  logic        up_rreq,
    input  logic [13:0] up_raddr,
    output logic        up_rack,
    output logic [31:0] up_rdata,
    output logic        up_rerr,
    output logic        up_busy,
    output logic        m_axi_awvalid,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    input  logic        m_axi_awready,
    output logic        m_axi_wvalid,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_wready,
    input  logic        m_axi_bvalid,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_bready,
    output logic        m_axi_arvalid,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_arready,
    input  logic        m_axi_rvalid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic [13:0]   pend_addr_q, pend_addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   araddr_q, araddr_d;
    logic          wack_q, wack_d;
    logic          werr_q, werr_d;
    logic          rack_q, rack_d;
    logic          rerr_q, rerr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_ok, w_ok, timeout, abort;

    assign aw_hs   = awvalid_q & m_axi_awready;
    assign w_hs    = wvalid_q & m_axi_wready;
    assign b_hs    = bready_q & m_axi_bvalid;
    assign ar_hs   = arvalid_q & m_axi_arready;
    assign r_hs    = rready_q & m_axi_rvalid;
    assign aw_ok   = aw_done_q | aw_hs;
    assign w_ok    = w_done_q | w_hs;
    // Fires on the edge where the counter would reach TIMEOUT; a completion on that same edge wins.
    assign timeout = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            wack_q      <= 1'b0;
            werr_q      <= 1'b0;
            rack_q      <= 1'b0;
            rerr_q      <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            wack_q      <= wack_d;
            werr_q      <= werr_d;
            rack_q      <= rack_d;
            rerr_q      <= rerr_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_wreq)      state_d = WR_REQ;
                else if (up_rreq) state_d = RD_REQ;
            end
            WR_REQ: begin
                if (aw_ok && w_ok) state_d = WR_RESP;
                else if (timeout) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) state_d = pend_q ? RD_REQ : IDLE;
                else if (timeout) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            RD_REQ: begin
                if (ar_hs) state_d = RD_RESP;
                else if (timeout) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            RD_RESP: begin
                if (r_hs || timeout) state_d = IDLE;
                abort = !r_hs && timeout;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        rdata_d     = rdata_q;
        wack_d      = 1'b0;
        werr_d      = 1'b0;
        rack_d      = 1'b0;
        rerr_d      = 1'b0;

        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q != IDLE && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        case (state_q)
            IDLE: begin
                if (up_wreq) begin
                    awaddr_d  = {16'b0, up_waddr, 2'b00};
                    wdata_d   = up_wdata;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (up_rreq) begin
                        pend_d      = 1'b1;
                        pend_addr_d = up_raddr;
                    end
                end else if (up_rreq) begin
                    araddr_d  = {16'b0, up_raddr, 2'b00};
                    arvalid_d = 1'b1;
                end
            end
            WR_REQ: begin
                if (abort) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    wack_d    = 1'b1;
                    werr_d    = 1'b1;
                    pend_d    = 1'b0;
                end else begin
                    if (aw_hs) begin
                        awvalid_d = 1'b0;
                        aw_done_d = 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end
                    if (aw_ok && w_ok) bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    wack_d   = 1'b1;
                    werr_d   = |m_axi_bresp;
                    if (pend_q) begin
                        pend_d    = 1'b0;
                        araddr_d  = {16'b0, pend_addr_q, 2'b00};
                        arvalid_d = 1'b1;
                    end
                end else if (abort) begin
                    bready_d = 1'b0;
                    wack_d   = 1'b1;
                    werr_d   = 1'b1;
                    pend_d   = 1'b0;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (abort) begin
                    arvalid_d = 1'b0;
                    rack_d    = 1'b1;
                    rerr_d    = 1'b1;
                    rdata_d   = 32'hDEAD_DEAD;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    rack_d   = 1'b1;
                    rerr_d   = |m_axi_rresp;
                    rdata_d  = m_axi_rdata;
                end else if (abort) begin
                    rready_d = 1'b0;
                    rack_d   = 1'b1;
                    rerr_d   = 1'b1;
                    rdata_d  = 32'hDEAD_DEAD;
                end
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE) || pend_d;
    end

    assign up_wack       = wack_q;
    assign up_werr       = werr_q;
    assign up_rack       = rack_q;
    assign up_rerr       = rerr_q;
    assign up_rdata      = rdata_q;
    assign up_busy       = busy_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_up_axi_master.sv
// Bench for up_axi_master: delay-programmable AXI4-Lite slave, transaction-level
// timing/outcome model, directed corner cases plus randomized transactions.
module tb_up_axi_master;

    localparam int TO = 8;

    logic        up_clk = 1'b0;
    logic        up_rst;
    logic        up_wreq, up_rreq;
    logic [13:0] up_waddr, up_raddr;
    logic [31:0] up_wdata, up_rdata;
    logic        up_wack, up_werr, up_rack, up_rerr, up_busy;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    up_axi_master #(.TIMEOUT(TO)) dut (
        .up_clk(up_clk), .up_rst(up_rst),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
        .up_wack(up_wack), .up_werr(up_werr),
        .up_rreq(up_rreq), .up_raddr(up_raddr),
        .up_rack(up_rack), .up_rdata(up_rdata), .up_rerr(up_rerr),
        .up_busy(up_busy),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awready(m_axi_awready),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rready(m_axi_rready)
    );

    always #5 up_clk = ~up_clk;

    int cyc = 0;
    always @(posedge up_clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave behaviour: each ready/valid rises once the master's valid/ready has been high for d+1 cycles.
    int d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = '0;
    int naw = 0, nw = 0, nb = 0, nar = 0, nr = 0;

    initial begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;   m_axi_rresp = 2'b00;
        forever begin
            @(negedge up_clk);
            naw = m_axi_awvalid ? naw + 1 : 0;
            nw  = m_axi_wvalid  ? nw + 1  : 0;
            nb  = m_axi_bready  ? nb + 1  : 0;
            nar = m_axi_arvalid ? nar + 1 : 0;
            nr  = m_axi_rready  ? nr + 1  : 0;
            m_axi_awready = m_axi_awvalid && (naw > d_aw);
            m_axi_wready  = m_axi_wvalid  && (nw > d_w);
            m_axi_bvalid  = m_axi_bready  && (nb > d_b);
            m_axi_bresp   = s_bresp;
            m_axi_arready = m_axi_arvalid && (nar > d_ar);
            m_axi_rvalid  = m_axi_rready  && (nr > d_r);
            m_axi_rdata   = s_rdata;
            m_axi_rresp   = s_rresp;
        end
    end

    // Monitor: cumulative event counts and most recent event cycles.
    int wack_n = 0, rack_n = 0, wack_at = -1, rack_at = -1, ew_n = 0;
    int awv_n = 0, wv_n = 0, arv_n = 0, ar_rise_at = -1, b_rise_at = -1;
    logic        wack_err = 1'b0, rack_err = 1'b0;
    logic [31:0] aw_seen = '0, w_seen = '0, ar_seen = '0;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_b = 1'b0;

    initial forever begin
        @(negedge up_clk);
        if (up_wack) begin wack_n++; wack_at = cyc; wack_err = up_werr; end
        if (up_rack) begin rack_n++; rack_at = cyc; rack_err = up_rerr; end
        if ((up_werr && !up_wack) || (up_rerr && !up_rack)) ew_n++;
        if (m_axi_awvalid) awv_n++;
        if (m_axi_wvalid)  wv_n++;
        if (m_axi_arvalid) arv_n++;
        if (m_axi_awvalid && !p_aw) aw_seen = m_axi_awaddr;
        if (m_axi_wvalid && !p_w)   w_seen = m_axi_wdata;
        if (m_axi_arvalid && !p_ar) begin ar_seen = m_axi_araddr; ar_rise_at = cyc; end
        if (m_axi_bready && !p_b)   b_rise_at = cyc;
        p_aw = m_axi_awvalid; p_w = m_axi_wvalid; p_ar = m_axi_arvalid; p_b = m_axi_bready;
    end

    // Reference: a phase lasting d+1 cycles completes unless that exceeds TO cycles, in which case
    // the ack lands right after the TO-th cycle of that phase.
    function automatic void model(input int d1, input int d2, output int off, output bit ab);
        if (d1 + 1 > TO) begin
            off = TO; ab = 1'b1;
        end else if (d2 + 1 > TO) begin
            off = d1 + 1 + TO; ab = 1'b1;
        end else begin
            off = d1 + d2 + 2; ab = 1'b0;
        end
    endfunction

    logic [31:0] exp_rdata = '0;
    int t0, w0, r0, av0, wv0, arv0, ew0;

    task automatic run_txn(input bit do_w, input bit do_r,
                           input logic [13:0] wa, input logic [31:0] wd,
                           input logic [13:0] ra, input logic [31:0] rd,
                           input int da, input int dw, input int db, input int dar, input int dr,
                           input logic [1:0] br, input logic [1:0] rr, input int extra);
        int  woff, roff, rstart, exp_w, exp_r;
        bit  wab, rab, rd_go;
        model((da > dw) ? da : dw, db, woff, wab);
        model(dar, dr, roff, rab);
        rd_go  = do_r && !(do_w && wab);
        rstart = do_w ? 1 + woff : 1;
        exp_w  = do_w ? 1 : 0;
        exp_r  = rd_go ? 1 : 0;
        d_aw = da; d_w = dw; d_b = db; d_ar = dar; d_r = dr;
        s_bresp = br; s_rresp = rr; s_rdata = rd;
        @(negedge up_clk);
        t0 = cyc; w0 = wack_n; r0 = rack_n; av0 = awv_n; wv0 = wv_n; arv0 = arv_n; ew0 = ew_n;
        up_wreq = do_w; up_waddr = wa; up_wdata = wd;
        up_rreq = do_r; up_raddr = ra;
        for (int i = 0; i < 100; i++) begin
            @(negedge up_clk);
            up_wreq = (extra > 0) && (cyc - t0 == extra);
            up_waddr = up_wreq ? 14'h3FFF : up_waddr;
            up_rreq = 1'b0;
            if ((cyc - t0 > extra + 1) && (wack_n - w0 >= exp_w) && (rack_n - r0 >= exp_r)) break;
        end
        repeat (3) @(negedge up_clk);
        check("wack_count", wack_n - w0, exp_w);
        if (do_w) begin
            check("wack_cycle", wack_at - t0, 1 + woff);
            check("werr", wack_err, wab ? 1'b1 : (br != 2'b00));
            check("awaddr", aw_seen, {16'b0, wa, 2'b00});
            check("wdata", w_seen, wd);
        end
        check("rack_count", rack_n - r0, exp_r);
        if (rd_go) begin
            exp_rdata = rab ? 32'hDEAD_DEAD : rd;
            check("rack_cycle", rack_at - t0, rstart + roff);
            check("rerr", rack_err, rab ? 1'b1 : (rr != 2'b00));
            check("araddr", ar_seen, {16'b0, ra, 2'b00});
            if (do_w) check("arvalid_at_wack", ar_rise_at - t0, 1 + woff);
        end
        check("rdata", up_rdata, exp_rdata);
        check("err_without_ack", ew_n - ew0, 0);
        check("busy_idle", up_busy, 1'b0);
    endtask

    function automatic int rnd_d();
        int r;
        r = int'($urandom_range(0, 15));
        return (r < 13) ? r % 8 : 255;
    endfunction

    initial begin
        up_rst = 1'b1; up_wreq = 1'b0; up_rreq = 1'b0;
        up_waddr = '0; up_raddr = '0; up_wdata = '0;
        repeat (3) @(negedge up_clk);
        check("rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                           up_wack, up_werr, up_rack, up_rerr, up_busy}, '0);
        check("rst_addr", {m_axi_awaddr, m_axi_araddr}, '0);
        check("rst_rdata", up_rdata, '0);
        check("const_prot_strb", {m_axi_awprot, m_axi_arprot, m_axi_wstrb}, 10'h00F);
        up_rst = 1'b0;

        // Always-ready write, minimum latency
        run_txn(1, 0, 14'h0010, 32'h1234_5678, '0, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00, -1);
        // Read with response held back 5 cycles and SLVERR
        run_txn(0, 1, '0, '0, 14'h0003, 32'hCAFE_0001, 0, 0, 0, 0, 5, 2'b00, 2'b10, -1);
        // wready 4 cycles after awready
        run_txn(1, 0, 14'h0123, 32'hA5A5_0F0F, '0, '0, 0, 4, 0, 0, 0, 2'b00, 2'b00, -1);
        check("awvalid_cycles", awv_n - av0, 1);
        check("wvalid_cycles", wv_n - wv0, 5);
        check("bready_rise", b_rise_at - t0, 6);
        // Simultaneous write + read, third request while busy
        run_txn(1, 1, 14'h0AAA, 32'h0BAD_F00D, 14'h0555, 32'h7777_1111, 0, 0, 0, 0, 0,
                2'b01, 2'b00, 2);
        // Read address never accepted
        run_txn(0, 1, '0, '0, 14'h1234, 32'h1111_2222, 0, 0, 0, 255, 0, 2'b00, 2'b00, -1);
        check("arvalid_cycles_timeout", arv_n - arv0, TO);
        // Response arriving on the last cycle before the abort
        run_txn(0, 1, '0, '0, 14'h0042, 32'h5555_AAAA, 0, 0, 0, 0, TO - 1, 2'b00, 2'b00, -1);
        // Write response timeout drops the queued read
        run_txn(1, 1, 14'h0077, 32'h0000_0001, 14'h0078, 32'h9999_9999, 0, 0, 255, 0, 0,
                2'b00, 2'b00, -1);

        // Asynchronous reset while waiting for the write response
        d_aw = 0; d_w = 0; d_b = 255;
        @(negedge up_clk);
        w0 = wack_n;
        up_wreq = 1'b1; up_waddr = 14'h0055; up_wdata = 32'hFEED_BEEF;
        @(negedge up_clk);
        up_wreq = 1'b0;
        @(negedge up_clk);
        check("pre_rst_bready", m_axi_bready, 1'b1);
        #1 up_rst = 1'b1;
        #1;
        check("async_rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                 m_axi_rready, up_wack, up_werr, up_rack, up_rerr, up_busy}, '0);
        check("async_rst_addr", {m_axi_awaddr, m_axi_araddr}, '0);
        check("async_rst_rdata", up_rdata, '0);
        exp_rdata = '0;
        @(negedge up_clk);
        up_rst = 1'b0;
        repeat (20) @(negedge up_clk);
        check("no_wack_after_rst", wack_n - w0, 0);

        for (int n = 0; n < 40; n++) begin
            int  kind;
            kind = int'($urandom_range(0, 2));
            run_txn(kind != 1, kind != 0, 14'($urandom), $urandom, 14'($urandom), $urandom,
                    rnd_d(), rnd_d(), rnd_d(), rnd_d(), rnd_d(),
                    2'($urandom), 2'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
